// File: rtl/sram_axi_arb.sv
// sram_axi_arb: round-robin two-master AXI4-Lite arbiter in front of a single SRAM slave
module sram_axi_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_m0_axi_awaddr,
    input  logic            i_m0_axi_awvalid,
    output logic            o_m0_axi_awready,
    input  logic [DW-1:0]   i_m0_axi_wdata,
    input  logic [DW/8-1:0] i_m0_axi_wstrb,
    input  logic            i_m0_axi_wvalid,
    output logic            o_m0_axi_wready,
    input  logic [AW-1:0]   i_m0_axi_araddr,
    input  logic            i_m0_axi_arvalid,
    output logic            o_m0_axi_arready,
    output logic [DW-1:0]   o_m0_axi_rdata,
    output logic            o_m0_axi_rvalid,
    input  logic            i_m0_axi_rready,
    input  logic [AW-1:0]   i_m1_axi_awaddr,
    input  logic            i_m1_axi_awvalid,
    output logic            o_m1_axi_awready,
    input  logic [DW-1:0]   i_m1_axi_wdata,
    input  logic [DW/8-1:0] i_m1_axi_wstrb,
    input  logic            i_m1_axi_wvalid,
    output logic            o_m1_axi_wready,
    input  logic [AW-1:0]   i_m1_axi_araddr,
    input  logic            i_m1_axi_arvalid,
    output logic            o_m1_axi_arready,
    output logic [DW-1:0]   o_m1_axi_rdata,
    output logic            o_m1_axi_rvalid,
    input  logic            i_m1_axi_rready,
    output logic [AW-1:0]   o_s_axi_awaddr,
    output logic            o_s_axi_awvalid,
    input  logic            i_s_axi_awready,
    output logic [DW-1:0]   o_s_axi_wdata,
    output logic [DW/8-1:0] o_s_axi_wstrb,
    output logic            o_s_axi_wvalid,
    input  logic            i_s_axi_wready,
    output logic [AW-1:0]   o_s_axi_araddr,
    output logic            o_s_axi_arvalid,
    input  logic            i_s_axi_arready,
    input  logic [DW-1:0]   i_s_axi_rdata,
    input  logic            i_s_axi_rvalid,
    output logic            o_s_axi_rready
);
    typedef enum logic {IDLE = 1'b0, RD_PEND = 1'b1} state_t;

    state_t r_state, w_state_nxt;
    logic   r_rr_ptr, r_rd_owner;
    logic   w_wreq0, w_wreq1, w_req0, w_req1;
    logic   w_rhs, w_open, w_grant, w_win, w_wr, w_aw_hs, w_ar_hs;

    assign w_wreq0 = i_m0_axi_awvalid & i_m0_axi_wvalid;
    assign w_wreq1 = i_m1_axi_awvalid & i_m1_axi_wvalid;
    assign w_req0  = w_wreq0 | i_m0_axi_arvalid;
    assign w_req1  = w_wreq1 | i_m1_axi_arvalid;

    // The SRAM rdata tracks the last address, so a new access may only go out once the pending read is consumed
    assign w_rhs   = i_s_axi_rvalid & o_s_axi_rready;
    assign w_open  = (r_state == IDLE) | w_rhs;
    assign w_grant = w_open & (w_req0 | w_req1);
    assign w_win   = (w_req0 & w_req1) ? r_rr_ptr : w_req1;
    assign w_wr    = w_win ? w_wreq1 : w_wreq0;

    assign o_s_axi_awaddr  = w_grant ? (w_win ? i_m1_axi_awaddr : i_m0_axi_awaddr) : '0;
    assign o_s_axi_wdata   = w_grant ? (w_win ? i_m1_axi_wdata  : i_m0_axi_wdata)  : '0;
    assign o_s_axi_wstrb   = w_grant ? (w_win ? i_m1_axi_wstrb  : i_m0_axi_wstrb)  : '0;
    assign o_s_axi_araddr  = w_grant ? (w_win ? i_m1_axi_araddr : i_m0_axi_araddr) : '0;
    assign o_s_axi_awvalid = w_grant & w_wr;
    assign o_s_axi_wvalid  = w_grant & w_wr;
    assign o_s_axi_arvalid = w_grant & ~w_wr;

    assign o_m0_axi_awready = o_s_axi_awvalid & ~w_win & i_s_axi_awready;
    assign o_m0_axi_wready  = o_s_axi_wvalid  & ~w_win & i_s_axi_wready;
    assign o_m0_axi_arready = o_s_axi_arvalid & ~w_win & i_s_axi_arready;
    assign o_m1_axi_awready = o_s_axi_awvalid &  w_win & i_s_axi_awready;
    assign o_m1_axi_wready  = o_s_axi_wvalid  &  w_win & i_s_axi_wready;
    assign o_m1_axi_arready = o_s_axi_arvalid &  w_win & i_s_axi_arready;

    assign w_aw_hs = o_s_axi_awvalid & i_s_axi_awready;
    assign w_ar_hs = o_s_axi_arvalid & i_s_axi_arready;

    assign o_m0_axi_rvalid = i_s_axi_rvalid & (r_state == RD_PEND) & ~r_rd_owner;
    assign o_m1_axi_rvalid = i_s_axi_rvalid & (r_state == RD_PEND) &  r_rd_owner;
    assign o_s_axi_rready  = (r_state == RD_PEND) & (r_rd_owner ? i_m1_axi_rready : i_m0_axi_rready);
    assign o_m0_axi_rdata  = i_s_axi_rdata;
    assign o_m1_axi_rdata  = i_s_axi_rdata;

    // Read-tracking state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next read state: a new AR keeps us pending, an R handshake alone retires the read
    always_comb begin
        w_state_nxt = r_state;
        if (w_ar_hs)    w_state_nxt = RD_PEND;
        else if (w_rhs) w_state_nxt = IDLE;
    end

    // Priority flips away from the master just accepted; read owner latched on AR acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_aw_hs | w_ar_hs) r_rr_ptr   <= ~w_win;
            if (w_ar_hs)           r_rd_owner <= w_win;
        end
    end
endmodule

// File: tb/tb_sram_axi_arb.sv
// tb_sram_axi_arb: scoreboard bench for the two-master SRAM arbiter with a behavioural SRAM slave
module tb_sram_axi_arb;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic s_awvalid, s_wvalid, s_arvalid, s_rvalid, s_rready;
    logic s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;

    typedef struct packed {logic m; logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
    wr_t         q_wr[$];
    logic [31:0] q_rd0[$], q_rd1[$];
    wr_t         mon_e;
    logic [31:0] mon_d;
    logic [31:0] mem [64];
    logic [31:0] r_last;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sram_axi_arb #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_axi_awaddr(m0_awaddr), .i_m0_axi_awvalid(m0_awvalid), .o_m0_axi_awready(m0_awready),
        .i_m0_axi_wdata(m0_wdata), .i_m0_axi_wstrb(m0_wstrb), .i_m0_axi_wvalid(m0_wvalid), .o_m0_axi_wready(m0_wready),
        .i_m0_axi_araddr(m0_araddr), .i_m0_axi_arvalid(m0_arvalid), .o_m0_axi_arready(m0_arready),
        .o_m0_axi_rdata(m0_rdata), .o_m0_axi_rvalid(m0_rvalid), .i_m0_axi_rready(m0_rready),
        .i_m1_axi_awaddr(m1_awaddr), .i_m1_axi_awvalid(m1_awvalid), .o_m1_axi_awready(m1_awready),
        .i_m1_axi_wdata(m1_wdata), .i_m1_axi_wstrb(m1_wstrb), .i_m1_axi_wvalid(m1_wvalid), .o_m1_axi_wready(m1_wready),
        .i_m1_axi_araddr(m1_araddr), .i_m1_axi_arvalid(m1_arvalid), .o_m1_axi_arready(m1_arready),
        .o_m1_axi_rdata(m1_rdata), .o_m1_axi_rvalid(m1_rvalid), .i_m1_axi_rready(m1_rready),
        .o_s_axi_awaddr(s_awaddr), .o_s_axi_awvalid(s_awvalid), .i_s_axi_awready(s_awready),
        .o_s_axi_wdata(s_wdata), .o_s_axi_wstrb(s_wstrb), .o_s_axi_wvalid(s_wvalid), .i_s_axi_wready(s_wready),
        .o_s_axi_araddr(s_araddr), .o_s_axi_arvalid(s_arvalid), .i_s_axi_arready(s_arready),
        .i_s_axi_rdata(s_rdata), .i_s_axi_rvalid(s_rvalid), .o_s_axi_rready(s_rready)
    );

    // SRAM model: word k resets to C0DE_0000|k, byte-strobed writes, rdata follows the last read address
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | i;
        end else if (s_awvalid && s_wvalid) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) mem[s_awaddr[7:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0;
            r_last   <= '0;
        end else if (s_arvalid) begin
            s_rvalid <= 1'b1;
            r_last   <= s_araddr;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    assign s_rdata = mem[r_last[7:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes/reads whenever a handshake is about to complete
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_awvalid && s_awready && s_wvalid && s_wready) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mon_e = q_wr.pop_front();
                    chk("wr_master", m1_awready, mon_e.m);
                    chk("wr_addr", s_awaddr, mon_e.a);
                    chk("wr_data", s_wdata, mon_e.d);
                    chk("wr_strb", s_wstrb, mon_e.s);
                end
            end
            if (m0_rvalid && m0_rready) begin
                if (q_rd0.size() == 0) chk("rd0_unexpected", 1, 0);
                else begin
                    mon_d = q_rd0.pop_front();
                    chk("rd0_data", m0_rdata, mon_d);
                end
            end
            if (m1_rvalid && m1_rready) begin
                if (q_rd1.size() == 0) chk("rd1_unexpected", 1, 0);
                else begin
                    mon_d = q_rd1.pop_front();
                    chk("rd1_data", m1_rdata, mon_d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_all;
        {m0_awvalid, m0_wvalid, m0_arvalid, m1_awvalid, m1_wvalid, m1_arvalid} = '0;
        {m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr} = '0;
        m0_wstrb = 4'hF;
        m1_wstrb = 4'hF;
    endtask

    task automatic reset_pulse;
        tick;
        rst_n = 1'b0;
        idle_all();
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, c1;
        idle_all();
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        settle();
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        tick;
        tick;
        rst_n = 1'b1;
        // single write then read back
        m0_awaddr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF; m0_awvalid = 1; m0_wvalid = 1;
        q_wr.push_back({1'b0, 32'h10, 32'hDEADBEEF, 4'hF});
        settle();
        chk("t1_m0_awready", m0_awready, 1);
        chk("t1_m0_wready", m0_wready, 1);
        chk("t1_s_awaddr", s_awaddr, 32'h10);
        chk("t1_m1_awready", m1_awready, 0);
        chk("t1_m1_wready", m1_wready, 0);
        tick;
        chk("t1_rr_ptr", dut.r_rr_ptr, 1);
        m0_awvalid = 0; m0_wvalid = 0;
        m0_araddr = 32'h10; m0_arvalid = 1;
        q_rd0.push_back(32'hDEADBEEF);
        settle();
        chk("t1_m0_arready", m0_arready, 1);
        tick;
        m0_arvalid = 0;
        tick;
        // contended reads, back-to-back in the R handshake cycle
        reset_pulse();
        m0_araddr = 32'h20; m0_arvalid = 1;
        m1_araddr = 32'h24; m1_arvalid = 1;
        q_rd0.push_back(32'hC0DE0008);
        q_rd1.push_back(32'hC0DE0009);
        settle();
        chk("t2_m0_arready", m0_arready, 1);
        chk("t2_m1_arready0", m1_arready, 0);
        tick;
        m0_arvalid = 0;
        settle();
        chk("t2_m0_rvalid", m0_rvalid, 1);
        chk("t2_m1_rvalid0", m1_rvalid, 0);
        chk("t2_m1_arready1", m1_arready, 1);
        tick;
        m1_arvalid = 0;
        settle();
        chk("t2_m1_rvalid1", m1_rvalid, 1);
        chk("t2_m0_rvalid1", m0_rvalid, 0);
        tick;
        // read stall blocks the other master's write
        m0_araddr = 32'h30; m0_arvalid = 1; m0_rready = 0;
        q_rd0.push_back(32'hC0DE000C);
        settle();
        chk("t3_m0_arready", m0_arready, 1);
        tick;
        m0_arvalid = 0;
        m1_awaddr = 32'h34; m1_wdata = 32'h12345678; m1_wstrb = 4'h3; m1_awvalid = 1; m1_wvalid = 1;
        q_wr.push_back({1'b1, 32'h34, 32'h12345678, 4'h3});
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_m1_awready_stall", m1_awready, 0);
            chk("t3_s_awvalid_stall", s_awvalid, 0);
            chk("t3_m0_rvalid_stall", m0_rvalid, 1);
            chk("t3_m0_rdata_stall", m0_rdata, 32'hC0DE000C);
            tick;
        end
        m0_rready = 1;
        settle();
        chk("t3_m1_awready_go", m1_awready, 1);
        tick;
        m1_awvalid = 0; m1_wvalid = 0;
        tick;
        // continuous write contention alternates grants
        c0 = 0; c1 = 0;
        m0_awvalid = 1; m0_wvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        for (int i = 0; i < 6; i++) begin
            m0_awaddr = 32'h40 + 32'(c0 * 4); m0_wdata = 32'hA0000000 + 32'(c0);
            m1_awaddr = 32'h80 + 32'(c1 * 4); m1_wdata = 32'hB0000000 + 32'(c1);
            if (i % 2 == 0) q_wr.push_back({1'b0, 32'h40 + 32'(c0 * 4), 32'hA0000000 + 32'(c0), 4'hF});
            else            q_wr.push_back({1'b1, 32'h80 + 32'(c1 * 4), 32'hB0000000 + 32'(c1), 4'hF});
            settle();
            chk("t4_m0_awready", m0_awready, (i % 2 == 0) ? 1 : 0);
            chk("t4_m1_awready", m1_awready, (i % 2 == 1) ? 1 : 0);
            tick;
            if (i % 2 == 0) c0++; else c1++;
        end
        idle_all();
        tick;
        // write beats read within one master; read returns the strobed write
        m0_awaddr = 32'h50; m0_wdata = 32'h55AA55AA; m0_awvalid = 1; m0_wvalid = 1;
        m0_araddr = 32'h34; m0_arvalid = 1;
        q_wr.push_back({1'b0, 32'h50, 32'h55AA55AA, 4'hF});
        q_rd0.push_back(32'hC0DE5678);
        settle();
        chk("t5_m0_awready", m0_awready, 1);
        chk("t5_m0_arready0", m0_arready, 0);
        chk("t5_s_arvalid0", s_arvalid, 0);
        tick;
        m0_awvalid = 0; m0_wvalid = 0;
        settle();
        chk("t5_m0_arready1", m0_arready, 1);
        tick;
        m0_arvalid = 0;
        settle();
        chk("t5_m0_rvalid", m0_rvalid, 1);
        tick;
        // reset while m1 owns a pending read
        m1_araddr = 32'h24; m1_arvalid = 1; m1_rready = 0;
        settle();
        chk("t6_m1_arready", m1_arready, 1);
        tick;
        m1_arvalid = 0;
        settle();
        chk("t6_m1_rvalid_pend", m1_rvalid, 1);
        rst_n = 0;
        m1_rready = 1;
        settle();
        chk("t6_m1_rvalid_rst", m1_rvalid, 0);
        chk("t6_s_rready_rst", s_rready, 0);
        tick;
        tick;
        rst_n = 1;
        m0_awaddr = 32'h60; m0_wdata = 32'h66; m0_awvalid = 1; m0_wvalid = 1;
        m1_awaddr = 32'h64; m1_wdata = 32'h77; m1_awvalid = 1; m1_wvalid = 1;
        q_wr.push_back({1'b0, 32'h60, 32'h66, 4'hF});
        settle();
        chk("t6_m0_awready", m0_awready, 1);
        chk("t6_m1_awready0", m1_awready, 0);
        tick;
        m0_awvalid = 0; m0_wvalid = 0;
        q_wr.push_back({1'b1, 32'h64, 32'h77, 4'hF});
        settle();
        chk("t6_m1_awready1", m1_awready, 1);
        tick;
        idle_all();
        for (int i = 0; i < 20 && (q_wr.size() + q_rd0.size() + q_rd1.size()) > 0; i++) tick;
        chk("end_q_wr", q_wr.size(), 0);
        chk("end_q_rd0", q_rd0.size(), 0);
        chk("end_q_rd1", q_rd1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
